ecc_pdbl_sequencer: RTL and testbench
=====================================

Name: ecc_pdbl_sequencer

Overview:
- Multi-cycle controller that computes affine point doubling (x3,y3) = 2·(x1,y1) over the secp256k1 prime field.
- It does this by issuing a fixed 12-step micro-sequence to one shared modular ALU (mul/add/sub/inv) through a req/ack handshake.
- It replaces instantiating separate combinational mod_mult/mod_inv/mod_sub blocks per operation, and sits between the scalar-multiply loop and the shared field ALU.
- It holds the operands and five WIDTH-bit temporaries (t0..t4) internally.

Parameters:
- WIDTH, 256, field element width.
- TMO_CYCLES, 4096, ALU ack timeout in cycles. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; captures x1_in/y1_in/inf_in.
- x1_in  input  WIDTH  affine x of input point.
- y1_in  input  WIDTH  affine y of input point.
- inf_in  input  1  input point is the point at infinity.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.
- x3  output  WIDTH  result x; held until the next accepted start.
- y3  output  WIDTH  result y; held until the next accepted start.
- inf_out  output  1  result is the point at infinity.
- alu_req  output  1  ALU request; held until alu_ack.
- alu_op  output  2  ALU opcode: 0 MUL a·b, 1 ADD a+b, 2 SUB a−b, 3 INV a⁻¹ (b don't-care). All ops are mod p.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_ack  input  1  one-cycle pulse; alu_res is valid in this cycle.
- alu_res  input  WIDTH  ALU result.
- err  output  1  timeout error; only exists with PD_TMO_EN.

Behaviour:
- Reset values: busy, done, alu_req, inf_out, err = 0; x3, y3, alu_a, alu_b = 0; alu_op = 0; FSM = IDLE.
- FSM states: IDLE → ISSUE → WAIT → (ISSUE | FIN) → IDLE.
- IDLE, start=1:
  - Latch x1_in, y1_in, inf_in; clear step counter to 0; go to ISSUE.
  - If inf_in=1 or y1_in=0, skip the ALU entirely: go to FIN with inf_out=1, x3=y3=0.
- ISSUE: drive alu_req=1 and alu_op/alu_a/alu_b for the current step; go to WAIT next cycle.
- WAIT:
  - Hold alu_req and operands stable until the cycle alu_ack=1.
  - In the ack cycle: write alu_res to the step's destination, drop alu_req on the next edge, increment step.
  - If step was 11, go to FIN; otherwise go to ISSUE.
  - Net cost is one idle cycle between consecutive requests.
- Micro-sequence (step: op dst = a,b):
  - 0 MUL t0=x,x
  - 1 ADD t1=t0,t0
  - 2 ADD t0=t1,t0
  - 3 ADD t1=y,y
  - 4 INV t1=t1
  - 5 MUL t2=t0,t1 (λ)
  - 6 MUL t3=t2,t2
  - 7 SUB t3=t3,x
  - 8 SUB t3=t3,x (x3)
  - 9 SUB t4=x,t3
  - 10 MUL t4=t2,t4
  - 11 SUB t4=t4,y (y3)
- FIN: load x3←t3, y3←t4, inf_out←0 (except on the skip path above); pulse done=1 for one cycle; busy falls in the same cycle; return to IDLE.
- Latency: with an ALU that acks in L cycles after req rises, start-to-done = 1 + 12·(L+1) + 1 cycles. Skip path: done occurs 2 cycles after start.
- start while busy: ignored; latched operands are unaffected.
- start in the done cycle: ignored. A new start is accepted only in IDLE.
- alu_ack while alu_req=0: ignored.
- rst_n low at any time: all state returns to reset values asynchronously; an outstanding request is abandoned (alu_req drops immediately).
- Temporaries are not reset-cleared beyond x3/y3 and are not observable.

Optional Feature:
- Macro: PD_TMO_EN.
- Defined:
  - A counter runs in WAIT. If TMO_CYCLES elapse without alu_ack: drop alu_req, set err=1, pulse done with x3, y3, inf_out unchanged, return to IDLE.
  - err clears on the next accepted start.
  - TMO_CYCLES must be ≥ 2.
- Undefined: no counter and no err port; WAIT waits forever.

Test Plan:
- Double generator G: start with x1=79BE667E…16F81798, y1=483ADA77…FB10D4B8 (full 256-bit values), fixed-latency ALU model L=3 → done at cycle 50; x3=C6047F94…5C709EE5, y3=1AE168FE…50CFE52A (full 256-bit values); inf_out=0; exactly 12 req/ack pairs.
- Sequencing check: monitor the alu_op stream = 0,1,1,1,3,0,0,2,2,2,0,2. alu_a/alu_b must be stable from req rise until ack; random ALU latency 1..20.
- Degenerate inputs: start with inf_in=1, then with y1=0 → done 2 cycles after start, inf_out=1, x3=y3=0, alu_req never asserted.
- Protocol: start pulses during busy and in the done cycle are ignored and the result still equals 2G; a spurious alu_ack while idle changes nothing.
- Reset mid-op: assert rst_n=0 during step 5 WAIT → busy=0, alu_req=0 immediately; after release, a fresh 2G computation is correct.
- PD_TMO_EN with TMO_CYCLES=16: ALU never acks → done 16 cycles into WAIT of step 0, err=1; the next start with a normal ALU gives err=0 and the correct 2G.

Source files
------------

// File: rtl/ecc_pdbl_sequencer.sv
// Affine point doubling over secp256k1 by sequencing 12 ops on one shared mod-p ALU.
// Define PD_TMO_EN to add an ALU ack timeout and the err output.
module ecc_pdbl_sequencer #(
    parameter int WIDTH      = 256,
    parameter int TMO_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x1_in,
    input  logic [WIDTH-1:0] y1_in,
    input  logic             inf_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] y3,
    output logic             inf_out,
    output logic             alu_req,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_ack,
    input  logic [WIDTH-1:0] alu_res,
`ifdef PD_TMO_EN
    output logic             err,
`endif
    output logic [1:0]       dbg_state_o
);

    // ALU handshake: alu_req rises together with alu_op/alu_a/alu_b, all held stable
    // until the cycle alu_ack=1 (alu_res valid then); req drops on the following edge.
    // alu_ack while alu_req=0 is ignored.
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_e;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_INV = 2'd3;

    // Operand sources: 0..4 are t0..t4, 5 is x, 6 is y.
    localparam logic [2:0] SRC_T0 = 3'd0;
    localparam logic [2:0] SRC_T1 = 3'd1;
    localparam logic [2:0] SRC_T2 = 3'd2;
    localparam logic [2:0] SRC_T3 = 3'd3;
    localparam logic [2:0] SRC_T4 = 3'd4;
    localparam logic [2:0] SRC_X  = 3'd5;
    localparam logic [2:0] SRC_Y  = 3'd6;

    if (TMO_CYCLES < 2) begin : g_tmo_chk
        $error("TMO_CYCLES must be at least 2");
    end

    state_e           state_q;
    logic             busy_q, done_q, req_q, inf_q, skip_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, x3_q, y3_q;
    logic [3:0]       step_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic [WIDTH-1:0] t_q [5];

    logic [1:0]       op_sel;
    logic [2:0]       sa_sel, sb_sel, dst_sel;
    logic [WIDTH-1:0] src_v [8];
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             accept, take;

`ifdef PD_TMO_EN
    localparam int TW = $clog2(TMO_CYCLES);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    assign err = err_q;
`endif

    assign accept = (state_q == S_IDLE) && start && !done_q;
    assign take   = (state_q == S_WAIT) && alu_ack;

    always_comb begin
        for (int i = 0; i < 5; i++) src_v[i] = t_q[i];
        src_v[5] = x_q;
        src_v[6] = y_q;
        src_v[7] = '0;
        op_sel  = OP_MUL;
        sa_sel  = SRC_X;
        sb_sel  = SRC_X;
        dst_sel = SRC_T0;
        // lambda = 3x^2 / 2y ; x3 = lambda^2 - 2x ; y3 = lambda(x - x3) - y
        case (step_q)
            4'd0:  begin op_sel = OP_MUL; sa_sel = SRC_X;  sb_sel = SRC_X;  dst_sel = SRC_T0; end
            4'd1:  begin op_sel = OP_ADD; sa_sel = SRC_T0; sb_sel = SRC_T0; dst_sel = SRC_T1; end
            4'd2:  begin op_sel = OP_ADD; sa_sel = SRC_T1; sb_sel = SRC_T0; dst_sel = SRC_T0; end
            4'd3:  begin op_sel = OP_ADD; sa_sel = SRC_Y;  sb_sel = SRC_Y;  dst_sel = SRC_T1; end
            4'd4:  begin op_sel = OP_INV; sa_sel = SRC_T1; sb_sel = SRC_T1; dst_sel = SRC_T1; end
            4'd5:  begin op_sel = OP_MUL; sa_sel = SRC_T0; sb_sel = SRC_T1; dst_sel = SRC_T2; end
            4'd6:  begin op_sel = OP_MUL; sa_sel = SRC_T2; sb_sel = SRC_T2; dst_sel = SRC_T3; end
            4'd7:  begin op_sel = OP_SUB; sa_sel = SRC_T3; sb_sel = SRC_X;  dst_sel = SRC_T3; end
            4'd8:  begin op_sel = OP_SUB; sa_sel = SRC_T3; sb_sel = SRC_X;  dst_sel = SRC_T3; end
            4'd9:  begin op_sel = OP_SUB; sa_sel = SRC_X;  sb_sel = SRC_T3; dst_sel = SRC_T4; end
            4'd10: begin op_sel = OP_MUL; sa_sel = SRC_T2; sb_sel = SRC_T4; dst_sel = SRC_T4; end
            4'd11: begin op_sel = OP_SUB; sa_sel = SRC_T4; sb_sel = SRC_Y;  dst_sel = SRC_T4; end
            default: ;
        endcase
        a_sel = src_v[sa_sel];
        b_sel = src_v[sb_sel];
    end

    // Operand and temporary storage carries no reset; it is never observable before being written.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q <= x1_in;
            y_q <= y1_in;
        end
        if (take) t_q[dst_sel] <= alu_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            inf_q   <= 1'b0;
            skip_q  <= 1'b0;
            op_q    <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            x3_q    <= '0;
            y3_q    <= '0;
            step_q  <= 4'd0;
`ifdef PD_TMO_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        step_q <= 4'd0;
`ifdef PD_TMO_EN
                        err_q  <= 1'b0;
`endif
                        // Doubling infinity or a point with y=0 yields infinity without the ALU.
                        if (inf_in || (y1_in == '0)) begin
                            skip_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            skip_q  <= 1'b0;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    req_q   <= 1'b1;
                    op_q    <= op_sel;
                    a_q     <= a_sel;
                    b_q     <= b_sel;
`ifdef PD_TMO_EN
                    tmo_q   <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_ack) begin
                        req_q   <= 1'b0;
                        step_q  <= step_q + 4'd1;
                        state_q <= (step_q == 4'd11) ? S_FIN : S_ISSUE;
                    end
`ifdef PD_TMO_EN
                    else if (tmo_q == TW'(TMO_CYCLES - 1)) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
`endif
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    inf_q   <= skip_q;
                    x3_q    <= skip_q ? '0 : t_q[3];
                    y3_q    <= skip_q ? '0 : t_q[4];
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign x3          = x3_q;
    assign y3          = y3_q;
    assign inf_out     = inf_q;
    assign alu_req     = req_q;
    assign alu_op      = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ecc_pdbl_sequencer.sv
// Bench for ecc_pdbl_sequencer: table vectors, random points against a field-arithmetic model,
// protocol/reset corner sequences, and the timeout path when PD_TMO_EN is defined.
module tb_ecc_pdbl_sequencer;
    localparam int W = 256;
`ifdef PD_TMO_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 4096;
`endif
    localparam logic [W-1:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [W-1:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [W-1:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [W-1:0] G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [W-1:0] G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;

    logic         clk = 1'b0;
    logic         rst_n, start, inf_in, busy, done, inf_out, alu_req;
    logic [W-1:0] x1_in, y1_in, x3, y3, alu_a, alu_b, alu_res;
    logic [1:0]   alu_op, dbg_state;
    logic         alu_ack, alu_ack_m, spur_ack;
`ifdef PD_TMO_EN
    logic         err;
`endif

    assign alu_ack = alu_ack_m | spur_ack;

    ecc_pdbl_sequencer #(.WIDTH(W), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x1_in(x1_in), .y1_in(y1_in), .inf_in(inf_in),
        .busy(busy), .done(done), .x3(x3), .y3(y3), .inf_out(inf_out),
        .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ack(alu_ack), .alu_res(alu_res),
`ifdef PD_TMO_EN
        .err(err),
`endif
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- field model ----------------
    function automatic logic [W-1:0] f_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] f_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a >= b) return a - b;
        return a + (P - b);
    endfunction

    function automatic logic [W-1:0] f_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] pr;
        pr = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        pr = pr % {{W{1'b0}}, P};
        return pr[W-1:0];
    endfunction

    function automatic logic [W-1:0] f_inv(input logic [W-1:0] a);
        logic [W-1:0] e, r, base;
        e = P - 256'd2;
        r = 256'd1;
        base = a;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = f_mul(r, base);
            base = f_mul(base, base);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] alu_compute(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0: return f_mul(a, b);
            2'd1: return f_add(a, b);
            2'd2: return f_sub(a, b);
            default: return f_inv(a);
        endcase
    endfunction

    // Affine doubling straight from the curve formulas.
    task automatic ref_double(input logic [W-1:0] x, input logic [W-1:0] y, input bit inf,
                              output logic [W-1:0] ex, output logic [W-1:0] ey, output bit einf);
        logic [W-1:0] lam;
        if (inf || y == '0) begin
            ex = '0; ey = '0; einf = 1'b1;
        end else begin
            lam  = f_mul(f_mul(256'd3, f_mul(x, x)), f_inv(f_add(y, y)));
            ex   = f_sub(f_mul(lam, lam), f_add(x, x));
            ey   = f_sub(f_mul(lam, f_sub(x, ex)), y);
            einf = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom())};
        if (r >= P) r = r - P;
        return r;
    endfunction

    // ---------------- ALU responder + op scoreboard ----------------
    logic [1:0]   ops_ref [12];
    logic [1:0]   exp_q [$];
    int           alu_lat = 3;
    bit           alu_silent = 1'b0;
    int           req_count = 0;

    initial begin : alu_model
        int           cnt, cur_lat;
        logic [1:0]   r_op, e_op;
        logic [W-1:0] r_a, r_b;
        bit           stable;
        alu_ack_m = 1'b0;
        alu_res   = '0;
        cnt = 0; cur_lat = 1; stable = 1'b1;
        r_op = 2'd0; r_a = '0; r_b = '0;
        forever begin
            @(negedge clk);
            alu_ack_m = 1'b0;
            if (!rst_n || !alu_req) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    req_count++;
                    r_op = alu_op; r_a = alu_a; r_b = alu_b; stable = 1'b1;
                    cur_lat = (alu_lat > 0) ? alu_lat : int'($urandom_range(1, 20));
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL alu_req_extra req_count=%0d op=%0d expected no request", req_count, alu_op);
                    end else begin
                        e_op = exp_q.pop_front();
                        chk("alu_op_stream", W'(alu_op), W'(e_op));
                    end
                end else if (alu_op !== r_op || alu_a !== r_a || alu_b !== r_b) begin
                    stable = 1'b0;
                end
                cnt++;
                if (cnt == cur_lat && !alu_silent) begin
                    chk("operands_stable", W'(stable), W'(1));
                    alu_ack_m = 1'b1;
                    alu_res   = alu_compute(r_op, r_a, r_b);
                end
            end
        end
    end

    // One doubling: start pulse, optional start during busy / in the done cycle.
    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input bit inf, input int lat,
                       input int busy_pulse, input bit done_pulse, output int lat_out);
        int k;
        bit got;
        alu_lat = lat;
        req_count = 0;
        exp_q.delete();
        if (!(inf || y == '0)) foreach (ops_ref[j]) exp_q.push_back(ops_ref[j]);
        @(negedge clk);
        x1_in = x; y1_in = y; inf_in = inf; start = 1'b1;
        k = 0; got = 1'b0; lat_out = -1;
        while (!got && k < 1000) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (k == 1) chk("busy_after_start", W'(busy), W'(1));
            if (busy_pulse > 0 && k == busy_pulse) begin
                start = 1'b1; x1_in = rand256(); y1_in = rand256(); inf_in = 1'($urandom_range(0, 1));
            end
            if (done) begin got = 1'b1; lat_out = k; end
        end
        chk("done_seen", W'(got), W'(1));
        if (got) begin
            chk("busy_low_at_done", W'(busy), W'(0));
            if (done_pulse) begin
                start = 1'b1; x1_in = rand256(); y1_in = rand256(); inf_in = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
            chk("done_one_cycle", W'(done), W'(0));
            if (done_pulse) chk("start_in_done_ignored", W'(busy), W'(0));
        end
    endtask

    typedef struct {
        logic [W-1:0] x, y;
        bit           inf;
        int           lat;
        logic [W-1:0] ex, ey;
        bit           einf;
        int           elat;
        int           nreq;
    } vec_t;

    vec_t tbl [5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int           lat_o, k;
        logic [W-1:0] ex, ey;
        bit           einf, inf_r;
        logic [W-1:0] xr, yr;

        ops_ref = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2};
        tbl[0] = '{GX, GY, 1'b0, 3, G2X, G2Y, 1'b0, 50, 12};
        tbl[1] = '{GX, GY, 1'b1, 3, '0,  '0,  1'b1, 2,  0};
        tbl[2] = '{GX, '0, 1'b0, 3, '0,  '0,  1'b1, 2,  0};
        tbl[3] = '{GX, GY, 1'b0, 1, G2X, G2Y, 1'b0, 26, 12};
        tbl[4] = '{GX, GY, 1'b0, 7, G2X, G2Y, 1'b0, 98, 12};

        rst_n = 1'b0; start = 1'b0; inf_in = 1'b0; x1_in = '0; y1_in = '0; spur_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_alu_req", W'(alu_req), W'(0));
        chk("rst_inf_out", W'(inf_out), W'(0));
        chk("rst_x3", x3, '0);
        chk("rst_y3", y3, '0);
        chk("rst_alu_op", W'(alu_op), W'(0));
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
`ifdef PD_TMO_EN
        chk("rst_err", W'(err), W'(0));
`endif

        foreach (tbl[i]) begin
            run(tbl[i].x, tbl[i].y, tbl[i].inf, tbl[i].lat, 0, 1'b0, lat_o);
            chk("tbl_latency", W'(lat_o), W'(tbl[i].elat));
            chk("tbl_x3", x3, tbl[i].ex);
            chk("tbl_y3", y3, tbl[i].ey);
            chk("tbl_inf_out", W'(inf_out), W'(tbl[i].einf));
            chk("tbl_req_count", W'(req_count), W'(tbl[i].nreq));
            chk("tbl_ops_drained", W'(exp_q.size()), W'(0));
        end

        for (int i = 0; i < 8; i++) begin
            xr = rand256(); yr = rand256();
            inf_r = ($urandom_range(0, 5) == 0);
            if (i == 3) yr = '0;
            ref_double(xr, yr, inf_r, ex, ey, einf);
            run(xr, yr, inf_r, 0, 0, 1'b0, lat_o);
            chk("rnd_x3", x3, ex);
            chk("rnd_y3", y3, ey);
            chk("rnd_inf_out", W'(inf_out), W'(einf));
            chk("rnd_req_count", W'(req_count), W'(einf ? 0 : 12));
        end

        run(GX, GY, 1'b0, 3, 5, 1'b1, lat_o);
        chk("prot_latency", W'(lat_o), W'(50));
        chk("prot_x3", x3, G2X);
        chk("prot_y3", y3, G2Y);
        chk("prot_req_count", W'(req_count), W'(12));

        @(negedge clk);
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        chk("spur_busy", W'(busy), W'(0));
        chk("spur_alu_req", W'(alu_req), W'(0));
        chk("spur_x3", x3, G2X);
        chk("spur_y3", y3, G2Y);

        alu_lat = 3; req_count = 0; exp_q.delete();
        foreach (ops_ref[j]) exp_q.push_back(ops_ref[j]);
        @(negedge clk);
        x1_in = GX; y1_in = GY; inf_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (req_count < 6 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("rstmid_step5_reached", W'(req_count), W'(6));
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", W'(busy), W'(0));
        chk("rstmid_alu_req", W'(alu_req), W'(0));
        chk("rstmid_x3", x3, '0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        run(GX, GY, 1'b0, 3, 0, 1'b0, lat_o);
        chk("rstmid_latency", W'(lat_o), W'(50));
        chk("rstmid_after_x3", x3, G2X);
        chk("rstmid_after_y3", y3, G2Y);

`ifdef PD_TMO_EN
        alu_silent = 1'b1; alu_lat = 3; req_count = 0; exp_q.delete();
        exp_q.push_back(2'd0);
        @(negedge clk);
        x1_in = GX; y1_in = GY; inf_in = 1'b0; start = 1'b1;
        k = 0;
        while (k < 100 && !done) begin
            @(negedge clk);
            k++;
            start = 1'b0;
        end
        chk("tmo_latency", W'(k), W'(2 + TMO));
        chk("tmo_err", W'(err), W'(1));
        chk("tmo_alu_req", W'(alu_req), W'(0));
        chk("tmo_busy", W'(busy), W'(0));
        chk("tmo_x3_held", x3, G2X);
        chk("tmo_y3_held", y3, G2Y);
        chk("tmo_inf_held", W'(inf_out), W'(0));
        alu_silent = 1'b0;
        run(GX, GY, 1'b0, 3, 0, 1'b0, lat_o);
        chk("tmo_next_err", W'(err), W'(0));
        chk("tmo_next_x3", x3, G2X);
        chk("tmo_next_y3", y3, G2Y);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
